flex_pts_buffered: RTL

FLEX_PTS_BUFFERED -- requirements
Module: flex_pts_buffered

---
 rtl/flex_pts_buffered_if.sv | 25 ++
 rtl/flex_pts_buffered.sv | 126 ++++++++++++
 2 files changed

// File: rtl/flex_pts_buffered_if.sv
// Handshake and serial-line bundle for the buffered parallel-to-serial shifter.
// The master side drives the word and bit-time controls; the slave side is the shifter.
interface flex_pts_buffered_if #(
  parameter int NUM_BITS = 8
);
  logic                shift_enable;
  logic                flush;
  logic                msb_first;
  logic                load_valid;
  logic [NUM_BITS-1:0] parallel_in;
  logic                load_ready;
  logic                serial_out;
  logic                busy;
  logic                word_done;

  modport master (
    output shift_enable, flush, msb_first, load_valid, parallel_in,
    input  load_ready, serial_out, busy, word_done
  );

  modport slave (
    input  shift_enable, flush, msb_first, load_valid, parallel_in,
    output load_ready, serial_out, busy, word_done
  );
endinterface

// File: rtl/flex_pts_buffered.sv
// Buffered parallel-to-serial shifter: a one-word holding register feeds a
// shift register so consecutive words leave the line back-to-back with no idle bit.
// Bit order is captured per word when the word moves into the shift register.
module flex_pts_buffered #(
  parameter int   NUM_BITS = 8,
  parameter logic IDLE_VAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  flex_pts_buffered_if.slave   bus
);

  localparam int CNT_W = $clog2(NUM_BITS + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] hold_reg;
  logic                hold_full_q, hold_full_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic                order_q, order_d;
  logic [CNT_W-1:0]    bits_left_q, bits_left_d;
  logic                word_done_q, word_done_d;
  logic                load_acc;
  logic                take_word;

  // Advance the shift register one position toward whichever end is driving the line.
  function automatic logic [NUM_BITS-1:0] shift_toward_out(
    input logic [NUM_BITS-1:0] cur,
    input logic                msb_out
  );
    if (msb_out)
      return {cur[NUM_BITS-2:0], IDLE_VAL};
    else
      return {IDLE_VAL, cur[NUM_BITS-1:1]};
  endfunction

  // The holding slot only accepts when empty, so a consumed word is never replaced on the same edge.
  assign load_acc = bus.load_valid && !hold_full_q;

  // Next-state logic: flush overrides everything; otherwise load, transfer and shift.
  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    order_d     = order_q;
    bits_left_d = bits_left_q;
    word_done_d = 1'b0;
    take_word   = 1'b0;

    if (bus.flush) begin
      state_d     = IDLE;
      hold_full_d = 1'b0;
      shift_d     = {NUM_BITS{IDLE_VAL}};
      bits_left_d = '0;
    end else begin
      if (load_acc)
        hold_full_d = 1'b1;

      case (state_q)
        IDLE: begin
          if (hold_full_q)
            take_word = 1'b1;
        end
        SHIFT: begin
          if (bus.shift_enable) begin
            if (bits_left_q > CNT_W'(1)) begin
              shift_d     = shift_toward_out(shift_q, order_q);
              bits_left_d = bits_left_q - CNT_W'(1);
            end else begin
              word_done_d = 1'b1;
              if (hold_full_q) begin
                take_word = 1'b1;
              end else begin
                state_d     = IDLE;
                shift_d     = {NUM_BITS{IDLE_VAL}};
                bits_left_d = '0;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (take_word) begin
        shift_d     = hold_reg;
        order_d     = bus.msb_first;
        bits_left_d = CNT_W'(NUM_BITS);
        hold_full_d = 1'b0;
        state_d     = SHIFT;
      end
    end
  end

  // Control and shift state, cleared asynchronously so an aborted word leaves nothing behind.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      shift_q     <= {NUM_BITS{IDLE_VAL}};
      order_q     <= 1'b1;
      bits_left_q <= '0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      order_q     <= order_d;
      bits_left_q <= bits_left_d;
      word_done_q <= word_done_d;
    end
  end

  // Holding data needs no reset: it is only read while hold_full_q qualifies it.
  always_ff @(posedge clk) begin
    if (load_acc && !bus.flush)
      hold_reg <= bus.parallel_in;
  end

  assign bus.load_ready = !hold_full_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.word_done  = word_done_q;
  assign bus.serial_out = (state_q == SHIFT) ?
                          (order_q ? shift_q[NUM_BITS-1] : shift_q[0]) : IDLE_VAL;

endmodule
